// File: rtl/axi4lite_regbank.sv
// AXI4-lite slave register bank: NUM_REGS 32-bit R/W registers exposed flat,
// with a one-cycle commit pulse per register on every in-range write.
module axi4lite_regbank #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic [NUM_REGS*32-1:0]   reg_o,
  output logic [NUM_REGS-1:0]      reg_wr_o
);

  // Handshake rule: a transfer happens on a rising edge where valid & ready are
  // both high; a source holds valid and its payload stable until that edge.

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return ((idx >> SEL_W) == '0) &&
           ({1'b0, idx[SEL_W-1:0]} < (SEL_W+1)'(NUM_REGS));
  endfunction

  logic              aw_full_q, aw_full_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic              w_full_q, w_full_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;

  logic              commit, aw_hs, w_hs, ar_hs, aw_ok, ar_ok;
  logic [SEL_W-1:0]  aw_sel, ar_sel;
  logic [IDX_W-1:0]  ar_idx;
  logic              unused_ok;

  assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  assign awready = ~aw_full_q & ~areset;
  assign wready  = ~w_full_q & ~areset;
  assign arready = ~rvalid_q & ~areset;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;
  assign commit = aw_full_q & w_full_q & (~bvalid_q | bready);

  assign aw_sel = aw_idx_q[SEL_W-1:0];
  assign aw_ok  = in_range(aw_idx_q);
  assign ar_idx = araddr[ADDR_WIDTH-1:2];
  assign ar_sel = ar_idx[SEL_W-1:0];
  assign ar_ok  = in_range(ar_idx);

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = wdata;
      wstrb_d  = wstrb;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    // Commit can only happen while both buffers are full, so it never races
    // a new AW/W acceptance; a B completing on the same edge is replaced.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
      if (aw_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_q[b]) regs_d[aw_sel][8*b +: 8] = wdata_q[8*b +: 8];
        end
        reg_wr_d[aw_sel] = 1'b1;
      end
    end

    if (rvalid_q && rready) rvalid_d = 1'b0;
    // Reads sample regs_q, so a same-edge write is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = ar_ok ? regs_q[ar_sel] : 32'h0;
      rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      reg_wr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_wr_q  <= reg_wr_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign reg_wr_o = reg_wr_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_o[32*k +: 32] = regs_q[k];
  end

endmodule
